// File: rtl/alu_seq_pkg.sv
// alu_pkg: opcodes, FSM states and iterative-op classification for alu_seq.
// ALU_DIV_EN adds DIVU/REMU to the iterative set.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13,
        ALU_R14   = 4'd14,
        ALU_R15   = 4'd15
    } aluctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iter(aluctrl_e c);
`ifdef ALU_DIV_EN
        return c inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
`else
        return c inside {ALU_MUL, ALU_MULHU};
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter_md.sv
// alu_iter_md: 1 bit/cycle shift-add multiplier; restoring unsigned divider when ALU_DIV_EN.
// {hi,lo} is the 2*W accumulator: product, or remainder/quotient for divide.
module alu_iter_md #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);
    localparam int SH_W = $clog2(W);

    logic [SH_W:0] cnt;
    logic [W-1:0]  bq, nlo, nhi;
    logic [W:0]    sum;

    assign done = busy && cnt == (SH_W + 1)'(W - 1);
    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);

`ifdef ALU_DIV_EN
    logic       div_q;
    logic [W:0] shl, dif;

    assign shl = {hi, lo[W-1]};
    assign dif = shl - {1'b0, bq};

    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    always_comb begin
        nlo = div_q ? {lo[W-2:0], ~dif[W]} : {sum[0], lo[W-1:1]};
        nhi = div_q ? (dif[W] ? shl[W-1:0] : dif[W-1:0]) : sum[W:1];
    end

    always_ff @(posedge clk) begin
        if (rst)
            div_q <= 1'b0;
        else if (start)
            div_q <= op;
    end
`else
    logic unused_op;

    assign unused_op = op;

    always_comb begin
        nlo = {sum[0], lo[W-1:1]};
        nhi = sum[W:1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            lo   <= '0;
            hi   <= '0;
            bq   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            lo   <= a;
            hi   <= '0;
            bq   <= b;
        end else if (busy) begin
            busy <= !done;
            cnt  <= cnt + 1'b1;
            lo   <= nlo;
            hi   <= nhi;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready on both sides; 1-cycle base ops, iterative MUL/MULHU.
// Define ALU_DIV_EN to add iterative DIVU/REMU.
module alu_seq
    import alu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               alusrc,
    input  logic [3:0]         aluctrl,
    input  logic [D_WIDTH-1:0] aluop1,
    input  logic [D_WIDTH-1:0] immop,
    input  logic [D_WIDTH-1:0] regop2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] aluout,
    output logic               eq,
    output logic               lt,
    output logic               ltu
);
    localparam int SH_W = $clog2(D_WIDTH);

    alu_state_e         state, state_nxt;
    aluctrl_e           op;
    logic [D_WIDTH-1:0] op2, res, res_q, md_lo, md_hi;
    logic [SH_W-1:0]    sh;
    logic               accept, iter, iter_q, hi_q, lt_c, ltu_c, md_done, unused_busy;

    assign op        = aluctrl_e'(aluctrl);
    assign op2       = alusrc ? immop : regop2;
    assign sh        = op2[SH_W-1:0];
    assign iter      = is_iter(op);
    assign lt_c      = $signed(aluop1) < $signed(op2);
    assign ltu_c     = aluop1 < op2;
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    // Iterative results are read straight from the datapath registers, which hold once done.
    assign aluout    = iter_q ? (hi_q ? md_hi : md_lo) : res_q;

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:  res = aluop1 + op2;
            ALU_SUB:  res = aluop1 - op2;
            ALU_AND:  res = aluop1 & op2;
            ALU_OR:   res = aluop1 | op2;
            ALU_XOR:  res = aluop1 ^ op2;
            ALU_SLL:  res = aluop1 << sh;
            ALU_SRL:  res = aluop1 >> sh;
            ALU_SRA:  res = $unsigned($signed(aluop1) >>> sh);
            ALU_SLT:  res = D_WIDTH'(lt_c);
            ALU_SLTU: res = D_WIDTH'(ltu_c);
            default:  res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (iter ? CALC : DONE) : IDLE;
            CALC:    state_nxt = md_done ? DONE : CALC;
            DONE:    state_nxt = out_ready ? (accept ? (iter ? CALC : DONE) : IDLE) : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            res_q  <= '0;
            iter_q <= 1'b0;
            hi_q   <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
            ltu    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                res_q  <= res;
                iter_q <= iter;
                hi_q   <= op == ALU_MULHU || op == ALU_REMU;
                eq     <= aluop1 == op2;
                lt     <= lt_c;
                ltu    <= ltu_c;
            end
        end
    end

    alu_iter_md #(.W(D_WIDTH)) u_md (
        .clk  (clk),
        .rst  (rst),
        .start(accept && iter),
        .op   (op == ALU_DIVU || op == ALU_REMU),
        .a    (aluop1),
        .b    (op2),
        .busy (unused_busy),
        .done (md_done),
        .lo   (md_lo),
        .hi   (md_hi)
    );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, alusrc = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, eq, lt, ltu;
    logic [3:0]  aluctrl = 4'd0;
    logic [31:0] aluop1 = '0, immop = '0, regop2 = '0, aluout;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.D_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alusrc(alusrc),
        .aluctrl(aluctrl), .aluop1(aluop1), .immop(immop), .regop2(regop2),
        .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout),
        .eq(eq), .lt(lt), .ltu(ltu)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return 32'($signed(a) >>> b[4:0]);
            4'd8:  return {31'd0, $signed(a) < $signed(b)};
            4'd9:  return {31'd0, a < b};
            4'd10: return p[31:0];
            4'd11: return p[63:32];
`ifdef ALU_DIV_EN
            4'd12: return b == 0 ? 32'hFFFF_FFFF : a / b;
            4'd13: return b == 0 ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] c);
`ifdef ALU_DIV_EN
        return (c >= 4'd10 && c <= 4'd13) ? 33 : 1;
`else
        return (c == 4'd10 || c == 4'd11) ? 33 : 1;
`endif
    endfunction

    // Called at a negedge; returns at the negedge where the result is first valid.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] r,
                         input logic [31:0] im, input logic src);
        logic [31:0] b;
        int n;
        logic rdy_seen;
        b = src ? im : r;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        aluctrl = c; aluop1 = a; regop2 = r; immop = im; alusrc = src; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; aluop1 = $urandom; regop2 = $urandom; immop = $urandom;
        alusrc = ~src; aluctrl = 4'($urandom);
        @(negedge clk);
        n = 1;
        rdy_seen = 1'b0;
        while (!out_valid && n < 100) begin
            rdy_seen |= in_ready;
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency op%0d", c), 32'(n), 32'(lat_of(c)));
        if (n > 1) chk("in_ready_calc", {31'd0, rdy_seen}, 32'd0);
        chk($sformatf("aluout op%0d", c), aluout, model(c, a, b));
        chk($sformatf("flags op%0d", c), {29'd0, eq, lt, ltu},
            {29'd0, a == b, $signed(a) < $signed(b), a < b});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] a, r, im;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {27'd0, out_valid, in_ready, eq, lt, ltu}, 32'b01000);
        chk("reset_aluout", aluout, 32'd0);

        aluctrl = 4'd10; aluop1 = 32'h1234; regop2 = 32'h5678; alusrc = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_hs", {30'd0, out_valid, in_ready}, 32'b01);
        chk("post_rst_aluout", aluout, 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n += int'(out_valid);
        end
        chk("abort_no_result", 32'(n), 32'd0);

        aluctrl = 4'd0; aluop1 = 32'd5; regop2 = 32'd7; alusrc = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("stream_add", {out_valid, aluout[30:0]}, {1'b1, 31'd12});
        chk("stream_add_full", aluout, 32'd12);
        aluctrl = 4'd1; aluop1 = 32'd3; regop2 = 32'd5;
        @(negedge clk);
        chk("stream_sub", aluout, 32'hFFFF_FFFE);
        chk("stream_sub_v", {31'd0, out_valid}, 32'd1);
        aluctrl = 4'd7; aluop1 = 32'h8000_0000; immop = 32'd4; alusrc = 1'b1;
        @(negedge clk);
        chk("stream_sra", aluout, 32'hF800_0000);
        chk("stream_sra_v", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        do_op(4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b0);
        do_op(4'd11, 32'hFFFF_FFFF, 32'd0, 32'd2, 1'b1);

        aluctrl = 4'd8; aluop1 = 32'hFFFF_FFFF; regop2 = 32'd1; alusrc = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hs_flags", {27'd0, out_valid, in_ready, eq, lt, ltu}, 32'b10010);
            chk("bp_aluout", aluout, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {31'd0, out_valid}, 32'd0);

`ifdef ALU_DIV_EN
        do_op(4'd12, 32'd100, 32'd7, 32'd0, 1'b0);
        do_op(4'd13, 32'd100, 32'd7, 32'd0, 1'b0);
        do_op(4'd12, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
        do_op(4'd13, 32'd9, 32'd0, 32'd0, 1'b0);
`else
        do_op(4'd12, 32'd100, 32'd7, 32'd0, 1'b0);
`endif
        do_op(4'd15, 32'h1234, 32'h1234, 32'd0, 1'b0);
        chk("op15_eq", {31'd0, eq}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            r  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_op(4'($urandom_range(0, 15)), a, r, im, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
